bnn_mlp_core: RTL and testbench
===============================

BNN_MLP_CORE -- requirements
Module: bnn_mlp_core

Interface
REQ-001 SHALL have no parameters; all widths are fixed: 4 inputs, 4 neurons, 16-bit weights, 16-bit bias.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port cmd_valid, input, 1 bit: qualifies cmd for one load beat.
REQ-005 SHALL have port cmd, input, 8 bits: load byte.
REQ-006 SHALL have port start, input, 1 bit: single-cycle request to evaluate the network.
REQ-007 SHALL have port busy, output, 1 bit: high while evaluation is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when results are updated.
REQ-009 SHALL have port results, output, 4 bits: neuron activations; bit j is neuron j.

Function
REQ-010 SHALL hold the following registers:
- x[3:0]: input vector.
- W[15:0]: weights; row j = W[4j+3:4j].
- B[15:0]: biases; bias j = signed two's-complement B[4j+3:4j], range -8..7.
REQ-011 SHALL use a load pointer ptr (0..4) and, on each cmd_valid beat while not busy, write and increment as follows:
- ptr=0: x <= cmd[3:0].
- ptr=1: W[7:0] <= cmd.
- ptr=2: W[15:8] <= cmd.
- ptr=3: B[7:0] <= cmd.
- ptr=4: B[15:8] <= cmd.
- Then ptr <= ptr+1, wrapping from 4 to 0.
REQ-012 SHALL ignore cmd_valid while busy=1; neither the registers nor ptr change.
REQ-013 SHALL encode each bit as 1 = +1 and 0 = -1; neuron j computes:
- p_j = popcount(XNOR(x, row j)), range 0..4.
- dot_j = 2*p_j - 4, range -4..+4.
- s_j = dot_j + bias_j, using at least 5-bit signed arithmetic with no overflow.
REQ-014 SHALL set activation bit j = 1 when s_j >= 0 (so s_j = 0 gives 1) and 0 otherwise.
REQ-015 SHALL implement FSM IDLE -> COMPUTE -> DONE -> IDLE:
- IDLE: start=1 goes to COMPUTE with idx=0.
- COMPUTE: evaluates neuron idx into a scratch register each cycle; after idx=3 goes to DONE.
- DONE: copies scratch to results, pulses done=1 for exactly one cycle, then returns to IDLE.
REQ-016 SHALL keep busy=1 exactly while in COMPUTE or DONE.
REQ-017 SHALL have fixed latency: with start sampled at edge N, done=1 and the new results are visible in the cycle after edge N+5.
REQ-018 SHALL ignore start while busy; results SHALL hold their value until the next DONE.
REQ-019 SHALL, when cmd_valid and start are both high in IDLE, apply the byte write first; the evaluation then uses the updated registers.
REQ-020 SHALL not check that all 5 bytes are loaded; start evaluates the current register contents.

Reset
REQ-021 SHALL, with rst_n=0 asynchronously, clear: x=0, W=0, B=0, ptr=0, scratch=0, results=0, busy=0, done=0, state IDLE.
REQ-022 SHALL, when rst_n asserts mid-evaluation, abort immediately; no done pulse is produced and results read 0.
REQ-023 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Verification
REQ-024 SHALL cover: load bytes 0F,FF,FF,00,00, then start -> results=4'b1111; done=1 exactly 5 edges after start; busy high for 5 cycles.
REQ-025 SHALL cover: load 00,FF,FF,00,00, then start -> results=4'b0000 (all sums -4); then load 00,FF,FF,44,44 (bias +4), then start -> results=4'b1111 (sum 0 tie gives 1).
REQ-026 SHALL cover: load 0A,5A,08,00,00 (W=16'h085A) -> results=4'b1101 (sums 4,-4,2,0); then load 0F,FF,FF,88,88 (bias -8) -> results=4'b0000.
REQ-027 SHALL cover: drive cmd_valid and start during busy -> no register, ptr or FSM change; results equal the pre-request evaluation.
REQ-028 SHALL cover: assert rst_n=0 two cycles after start -> busy=0, done never pulses, results=0, ptr=0; a reload plus start after release gives correct results.

Source files
------------

// File: rtl/bnn_mlp_core.sv
// bnn_mlp_core: 4-input, 4-neuron binarized layer evaluated one neuron per cycle
module bnn_mlp_core (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   input  logic [7:0] cmd,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic [3:0] results
);
   typedef enum logic [1:0] {S_IDLE, S_COMP, S_FIN} state_t;
   state_t      state;
   logic [3:0]  x, scratch, row, bias, xn;
   logic [15:0] w, b;
   logic [2:0]  ptr, pop;
   logic [1:0]  idx;
   logic [5:0]  sum;
   logic        act;
   // 6-bit modular sum covers -12..11; the sign bit alone decides the activation
   always_comb begin
      row = w[{idx, 2'b00} +: 4];
      bias = b[{idx, 2'b00} +: 4];
      xn = ~(x ^ row);
      pop = 3'(xn[0]) + 3'(xn[1]) + 3'(xn[2]) + 3'(xn[3]);
      sum = {2'b00, pop, 1'b0} - 6'd4 + {{2{bias[3]}}, bias};
      act = ~sum[5];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         x <= '0;
         w <= '0;
         b <= '0;
         ptr <= '0;
         idx <= '0;
         scratch <= '0;
         results <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (cmd_valid && !busy) begin
            case (ptr)
               3'd0: x <= cmd[3:0];
               3'd1: w[7:0] <= cmd;
               3'd2: w[15:8] <= cmd;
               3'd3: b[7:0] <= cmd;
               default: b[15:8] <= cmd;
            endcase
            ptr <= (ptr == 3'd4) ? 3'd0 : ptr + 3'd1;
         end
         case (state)
            S_IDLE: if (start) begin
               state <= S_COMP;
               idx <= '0;
               busy <= 1'b1;
            end
            S_COMP: begin
               scratch[idx] <= act;
               idx <= idx + 2'd1;
               if (idx == 2'd3) state <= S_FIN;
            end
            default: begin
               results <= scratch;
               done <= 1'b1;
               busy <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_bnn_mlp_core.sv
// tb_bnn_mlp_core: directed and random checks of bnn_mlp_core against a byte-level model
module tb_bnn_mlp_core;
   logic       clk = 1'b0;
   logic       rst_n, cmd_valid, start;
   logic [7:0] cmd;
   logic       busy, done;
   logic [3:0] results;
   int         n_chk = 0, n_fail = 0;
   logic [7:0] bytes [5];
   int         mptr;

   bnn_mlp_core dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd),
      .start(start), .busy(busy), .done(done), .results(results)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: bits are +1/-1, activation is sign of dot product plus bias
   function automatic logic [3:0] model();
      logic [3:0] r;
      logic [3:0] xv = bytes[0][3:0];
      logic [15:0] wv = {bytes[2], bytes[1]};
      logic [15:0] bv = {bytes[4], bytes[3]};
      for (int j = 0; j < 4; j++) begin
         int dot = 0;
         int bi = int'(bv[4*j +: 4]);
         if (bi >= 8) bi -= 16;
         for (int i = 0; i < 4; i++) dot += (xv[i] == wv[4*j+i]) ? 1 : -1;
         r[j] = (dot + bi) >= 0;
      end
      return r;
   endfunction

   task automatic beat(input logic [7:0] c);
      cmd = c;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      bytes[mptr] = c;
      mptr = (mptr + 1) % 5;
   endtask

   task automatic load5(input logic [39:0] v);
      for (int i = 4; i >= 0; i--) beat(v[8*i +: 8]);
   endtask

   // Pulse start, check busy window, done timing and results; optional busy-time noise
   task automatic run(input string tag, input logic [3:0] exp, input bit noise);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check({tag, "_busy"}, busy, 1);
         check({tag, "_done_early"}, done, 0);
         if (noise) begin
            cmd_valid = 1'b1;
            cmd = 8'($urandom);
            start = 1'b1;
         end
         @(negedge clk);
         cmd_valid = 1'b0;
         start = 1'b0;
      end
      check({tag, "_done"}, done, 1);
      check({tag, "_busy_end"}, busy, 0);
      check({tag, "_results"}, results, exp);
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_results_hold"}, results, exp);
   endtask

   initial begin
      rst_n = 1'b0;
      cmd_valid = 1'b0;
      start = 1'b0;
      cmd = '0;
      mptr = 0;
      for (int i = 0; i < 5; i++) bytes[i] = '0;
      #12;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_results", results, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      load5(40'h0F_FF_FF_00_00);
      run("all_ones", 4'b1111, 0);
      load5(40'h00_FF_FF_00_00);
      run("all_neg", 4'b0000, 0);
      load5(40'h00_FF_FF_44_44);
      run("tie", 4'b1111, 0);
      load5(40'h0A_5A_08_00_00);
      run("mixed", 4'b1101, 0);
      load5(40'h0F_FF_FF_88_88);
      run("bias_m8", 4'b0000, 0);
      check("model_mixed", model(), 4'b0000);

      // Busy-time requests are ignored; a following full load must land from ptr 0
      load5(40'h03_C3_5A_17_E2);
      run("noise", model(), 1);
      repeat (3) begin
         @(negedge clk);
         check("noise_no_retrigger", done, 0);
      end
      load5(40'h06_A5_3C_F1_70);
      run("after_noise", model(), 0);

      // Last byte written in the same cycle as start must be used
      for (int i = 4; i > 0; i--) beat(8'($urandom));
      cmd = 8'($urandom);
      cmd_valid = 1'b1;
      bytes[4] = cmd;
      mptr = 0;
      run("cmd_with_start", model(), 0);

      // Reset during evaluation
      load5(40'h0F_FF_FF_00_00);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_results", results, 0);
      for (int i = 0; i < 5; i++) bytes[i] = '0;
      mptr = 0;
      repeat (6) begin
         @(negedge clk);
         check("abort_no_done", done, 0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_results", results, 0);
      run("post_rst_zero_regs", model(), 0);
      load5(40'h0A_5A_08_00_00);
      run("post_rst_reload", 4'b1101, 0);

      // Random full and partial loads
      for (int t = 0; t < 24; t++) begin
         int nb = (t % 3 == 0) ? int'($urandom_range(1, 4)) : 5;
         for (int i = 0; i < nb; i++) beat(8'($urandom));
         run("random", model(), t % 4 == 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
